// File: rtl/dds_multi_ch_if.sv
// Register bus bundle for dds_multi_ch: one write port and one read port
// with a registered read response.
interface dds_multi_ch_if #(
   parameter int ADDR_W = 16
);
   logic              wr;
   logic [ADDR_W-1:0] waddr;
   logic [15:0]       wdata;
   logic              rd;
   logic [ADDR_W-1:0] raddr;
   logic [15:0]       rdata;
   logic              rvalid;

   modport master (
      output wr, waddr, wdata, rd, raddr,
      input  rdata, rvalid
   );

   modport slave (
      input  wr, waddr, wdata, rd, raddr,
      output rdata, rvalid
   );
endinterface

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS generator. Each channel has a phase accumulator, a
// 16-bit phase offset and a shared quarter-wave sine LUT. Waveforms: sine,
// cosine, square, sawtooth. Four-stage output pipeline (A..D) gives a fixed
// latency of four edges from the accumulator value to dout.
module dds_multi_ch #(
   parameter int NCH    = 2,
   parameter int ACC_W  = 32,
   parameter int LUT_AW = 8,
   parameter int DOUT_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   dds_multi_ch_if.slave         bus,
   output logic [NCH-1:0]        out_valid,
   output logic [NCH*DOUT_W-1:0] dout
);

   localparam int LUT_N = 2 ** LUT_AW;

   localparam logic [1:0] MODE_SIN = 2'd0;
   localparam logic [1:0] MODE_COS = 2'd1;
   localparam logic [1:0] MODE_SQR = 2'd2;
   localparam logic [1:0] MODE_SAW = 2'd3;

   localparam logic [DOUT_W-1:0] POS_FS = {1'b0, {(DOUT_W-1){1'b1}}};
   localparam logic [DOUT_W-1:0] NEG_FS = {1'b1, {(DOUT_W-2){1'b0}}, 1'b1};
   localparam logic [ACC_W-1:0]  QTR    = {2'b01, {(ACC_W-2){1'b0}}};

   localparam real PI  = 3.14159265358979323846;
   localparam real AMP = real'((2 ** (DOUT_W-1)) - 1);

   // Quarter-wave table, sampled at half-step offsets so no entry is zero
   // and the negated value never reaches the most negative code.
   logic [DOUT_W-1:0] lut_rom [LUT_N];

   for (genvar i = 0; i < LUT_N; i++) begin : g_lut
      localparam real ANG  = PI / 2.0 * (real'(i) + 0.5) / real'(LUT_N);
      localparam int  LVAL = $rtoi(AMP * $sin(ANG) + 0.5);
      assign lut_rom[i] = LVAL[DOUT_W-1:0];
   end

   // Square and sawtooth values derived directly from the top phase bits.
   function automatic logic [DOUT_W-1:0] alt_sample(input logic [1:0] mode,
                                                    input logic [DOUT_W-1:0] top);
      logic [DOUT_W-1:0] res;
      res = '0;
      case (mode)
         MODE_SQR: res = top[DOUT_W-1] ? NEG_FS : POS_FS;
         MODE_SAW: res = {~top[DOUT_W-1], top[DOUT_W-2:0]};
         default:  res = '0;
      endcase
      return res;
   endfunction

   // Register bank
   logic [15:0]       shadow_r [NCH];
   logic [ACC_W-1:0]  ftw_r    [NCH];
   logic [15:0]       pow_r    [NCH];
   logic [1:0]        mode_r   [NCH];
   logic [NCH-1:0]    en_r;

   // Write decode
   logic              w_top_ok_s;
   logic              r_top_ok_s;
   logic [NCH-1:0]    lo_we_s, hi_we_s, pow_we_s, ctrl_we_s, prst_s;
   logic              sync_s;
   logic [ACC_W-1:0]  ftw_new_s [NCH];
   logic [15:0]       rd_val_s;

   // Datapath
   logic [ACC_W-1:0]  acc_r    [NCH];
   logic [ACC_W-1:0]  phase_r  [NCH];
   logic [1:0]        mode_a_r [NCH];
   logic [1:0]        mode_b_r [NCH];
   logic [1:0]        mode_c_r [NCH];
   logic [NCH-1:0]    vld_a_r, vld_b_r, vld_c_r;
   logic [NCH-1:0]    neg_b_r, neg_c_r;
   logic [LUT_AW-1:0] addr_b_r [NCH];
   logic [DOUT_W-1:0] alt_b_r  [NCH];
   logic [DOUT_W-1:0] alt_c_r  [NCH];
   logic [DOUT_W-1:0] lut_c_r  [NCH];

   assign w_top_ok_s = (bus.waddr[ADDR_W-1:8] == '0);
   assign r_top_ok_s = (bus.raddr[ADDR_W-1:8] == '0);

   // Decode a bus write into per-channel register strobes and the SYNC strobe.
   always_comb begin
      lo_we_s   = '0;
      hi_we_s   = '0;
      pow_we_s  = '0;
      ctrl_we_s = '0;
      prst_s    = '0;
      sync_s    = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         ftw_new_s[c] = ACC_W'({bus.wdata, shadow_r[c]});
         if (bus.wr && w_top_ok_s && (bus.waddr[7:4] == 4'(c))) begin
            case (bus.waddr[3:0])
               4'h0: lo_we_s[c]  = 1'b1;
               4'h1: hi_we_s[c]  = 1'b1;
               4'h2: pow_we_s[c] = 1'b1;
               4'h3: begin
                  ctrl_we_s[c] = 1'b1;
                  prst_s[c]    = bus.wdata[1];
               end
               default: lo_we_s[c] = 1'b0;
            endcase
         end else begin
            lo_we_s[c] = 1'b0;
         end
      end
      if (bus.wr && w_top_ok_s && (bus.waddr[7:0] == 8'hF0)) begin
         sync_s = bus.wdata[0];
      end else begin
         sync_s = 1'b0;
      end
   end

   // Read mux over current register contents; strobes and unmapped slots read 0.
   always_comb begin
      rd_val_s = 16'h0000;
      for (int c = 0; c < NCH; c++) begin
         if (r_top_ok_s && (bus.raddr[7:4] == 4'(c))) begin
            case (bus.raddr[3:0])
               4'h0:    rd_val_s = ftw_r[c][15:0];
               4'h1:    rd_val_s = 16'(ftw_r[c] >> 16);
               4'h2:    rd_val_s = pow_r[c];
               4'h3:    rd_val_s = {12'h000, mode_r[c], 1'b0, en_r[c]};
               default: rd_val_s = 16'h0000;
            endcase
         end else begin
            rd_val_s = rd_val_s;
         end
      end
   end

   // Register bank update; FTW_HI commits shadow and high half together.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int c = 0; c < NCH; c++) begin
            shadow_r[c] <= 16'h0000;
            ftw_r[c]    <= '0;
            pow_r[c]    <= 16'h0000;
            mode_r[c]   <= 2'b00;
         end
         en_r <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (lo_we_s[c])   shadow_r[c] <= bus.wdata;
            if (hi_we_s[c])   ftw_r[c]    <= ftw_new_s[c];
            if (pow_we_s[c])  pow_r[c]    <= bus.wdata;
            if (ctrl_we_s[c]) begin
               en_r[c]   <= bus.wdata[0];
               mode_r[c] <= bus.wdata[3:2];
            end
         end
      end
   end

   // Registered read response, one cycle after rd.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bus.rdata  <= 16'h0000;
         bus.rvalid <= 1'b0;
      end else begin
         bus.rvalid <= bus.rd;
         bus.rdata  <= bus.rd ? rd_val_s : 16'h0000;
      end
   end

   // Accumulators and the four-stage sample pipeline for every channel.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int c = 0; c < NCH; c++) begin
            acc_r[c]    <= '0;
            phase_r[c]  <= '0;
            mode_a_r[c] <= 2'b00;
            mode_b_r[c] <= 2'b00;
            mode_c_r[c] <= 2'b00;
            addr_b_r[c] <= '0;
            alt_b_r[c]  <= '0;
            alt_c_r[c]  <= '0;
            lut_c_r[c]  <= '0;
         end
         vld_a_r   <= '0;
         vld_b_r   <= '0;
         vld_c_r   <= '0;
         neg_b_r   <= '0;
         neg_c_r   <= '0;
         out_valid <= '0;
         dout      <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            // Clear wins over the add; a disabled channel holds its phase.
            if (prst_s[c] || sync_s) begin
               acc_r[c] <= '0;
            end else if (en_r[c]) begin
               acc_r[c] <= acc_r[c] + ftw_r[c];
            end else begin
               acc_r[c] <= acc_r[c];
            end

            // Stage A: phase from the pre-update accumulator.
            phase_r[c]  <= acc_r[c] + {pow_r[c], {(ACC_W-16){1'b0}}}
                           + ((mode_r[c] == MODE_COS) ? QTR : '0);
            mode_a_r[c] <= mode_r[c];
            vld_a_r[c]  <= en_r[c];

            // Stage B: quadrant fold into a quarter-wave address.
            neg_b_r[c]  <= phase_r[c][ACC_W-1];
            addr_b_r[c] <= phase_r[c][ACC_W-2] ? ~phase_r[c][ACC_W-3 -: LUT_AW]
                                               :  phase_r[c][ACC_W-3 -: LUT_AW];
            alt_b_r[c]  <= alt_sample(mode_a_r[c], phase_r[c][ACC_W-1 -: DOUT_W]);
            mode_b_r[c] <= mode_a_r[c];
            vld_b_r[c]  <= vld_a_r[c];

            // Stage C: table lookup.
            lut_c_r[c]  <= lut_rom[addr_b_r[c]];
            neg_c_r[c]  <= neg_b_r[c];
            alt_c_r[c]  <= alt_b_r[c];
            mode_c_r[c] <= mode_b_r[c];
            vld_c_r[c]  <= vld_b_r[c];

            // Stage D: select waveform, zero the sample when not valid.
            out_valid[c] <= vld_c_r[c];
            dout[c*DOUT_W +: DOUT_W] <=
               !vld_c_r[c]     ? '0 :
               mode_c_r[c][1]  ? alt_c_r[c] :
               neg_c_r[c]      ? -lut_c_r[c] : lut_c_r[c];
         end
      end
   end

endmodule
